sccomp_run_ctrl: RTL

Synthesizable run and debug controller that sits between a top-level harness (or board I/O) and the single-cycle CPU wrapper sccomp.
- Sequences the core's reset and runs it under a clock enable.
- Stops on a programmable halt PC or a cycle limit.
- Sweeps the register-file probe port (reg_sel/reg_data) and streams every register out over a valid/ready interface.
- Parametrised successor of the hand-written sim sequence: reset pulse, cycle counter, halt-PC stop, single reg_sel peek.

---
 rtl/sccomp_run_ctrl_pkg.sv | 19 +
 rtl/sccomp_reg_dump.sv | 70 +++++++
 rtl/sccomp_run_ctrl.sv | 133 +++++++++++++
 3 files changed

// File: rtl/sccomp_run_ctrl_pkg.sv
// Shared constants for the sccomp debug blocks: run-controller and dump
// sequencer state encodings plus default stop conditions.
package sccomp_run_ctrl_pkg;

  localparam logic [2:0] S_IDLE     = 3'd0;
  localparam logic [2:0] S_RESET    = 3'd1;
  localparam logic [2:0] S_RUN      = 3'd2;
  localparam logic [2:0] S_DUMP_SEL = 3'd3;
  localparam logic [2:0] S_DUMP_OUT = 3'd4;
  localparam logic [2:0] S_DONE     = 3'd5;

  localparam logic [1:0] D_IDLE = 2'd0;
  localparam logic [1:0] D_SEL  = 2'd1;
  localparam logic [1:0] D_OUT  = 2'd2;

  localparam logic [31:0] DEF_HALT_PC    = 32'h0000_0100;
  localparam int          DEF_MAX_CYCLES = 1000;

endpackage

// File: rtl/sccomp_reg_dump.sv
// Register-file dump sequencer: walks reg_sel over 0..NUM_REGS-1 and streams
// each probed value out as one registered valid/ready beat.
module sccomp_reg_dump
  import sccomp_run_ctrl_pkg::*;
#(
  parameter int REG_W    = 32,
  parameter int SEL_W    = 5,
  parameter int NUM_REGS = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             go,
  output logic             finished,
  output logic             out_phase,
  output logic [SEL_W-1:0] reg_sel,
  input  logic [REG_W-1:0] reg_data,
  output logic             dump_valid,
  input  logic             dump_ready,
  output logic [SEL_W-1:0] dump_idx,
  output logic [REG_W-1:0] dump_data
);

  localparam logic [SEL_W-1:0] LAST_IDX = SEL_W'(NUM_REGS - 1);

  logic [1:0] d_state;

  // Handshake: a beat transfers on a rising edge where dump_valid && dump_ready;
  // dump_idx/dump_data are frozen from the SEL->OUT edge until that transfer.
  assign finished  = (d_state == D_OUT) && dump_valid && dump_ready && (reg_sel == LAST_IDX);
  assign out_phase = (d_state == D_OUT);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      d_state    <= D_IDLE;
      reg_sel    <= '0;
      dump_valid <= 1'b0;
      dump_idx   <= '0;
      dump_data  <= '0;
    end else begin
      case (d_state)
        D_IDLE: begin
          if (go) begin
            d_state <= D_SEL;
            reg_sel <= '0;
          end
        end
        D_SEL: begin
          // reg_data has had a full cycle to settle on the new reg_sel.
          d_state    <= D_OUT;
          dump_data  <= reg_data;
          dump_idx   <= reg_sel;
          dump_valid <= 1'b1;
        end
        D_OUT: begin
          if (dump_valid && dump_ready) begin
            dump_valid <= 1'b0;
            if (reg_sel == LAST_IDX) begin
              d_state <= D_IDLE;
            end else begin
              reg_sel <= reg_sel + SEL_W'(1);
              d_state <= D_SEL;
            end
          end
        end
        default: d_state <= D_IDLE;
      endcase
    end
  end

endmodule

// File: rtl/sccomp_run_ctrl.sv
// Run/debug controller for sccomp: pulses core reset, runs it until the halt PC
// or the cycle limit, then dumps the register file over valid/ready.
module sccomp_run_ctrl
  import sccomp_run_ctrl_pkg::*;
#(
  parameter int              PC_W       = 32,
  parameter int              REG_W      = 32,
  parameter int              SEL_W      = 5,
  parameter int              NUM_REGS   = 32,
  parameter logic [PC_W-1:0] HALT_PC    = PC_W'(DEF_HALT_PC),
  parameter int              MAX_CYCLES = DEF_MAX_CYCLES,
  parameter int              RST_CYCLES = 2,
  parameter int              CNT_W      = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [PC_W-1:0]  cpu_pc,
  output logic             cpu_rstn,
  output logic             cpu_run,
  output logic [SEL_W-1:0] reg_sel,
  input  logic [REG_W-1:0] reg_data,
  output logic             dump_valid,
  input  logic             dump_ready,
  output logic [SEL_W-1:0] dump_idx,
  output logic [REG_W-1:0] dump_data,
  output logic             busy,
  output logic             done,
  output logic             halted,
  output logic             timeout,
  output logic [CNT_W-1:0] cycle_count,
  output logic [2:0]       dbg_state
);

  localparam int RC_W = $clog2(RST_CYCLES + 1);

  logic [2:0]      state, state_nx;
  logic [RC_W-1:0] rst_cnt;
  logic            hit_halt, hit_limit, dump_go, dump_finished, dump_out_phase;

  assign hit_halt  = (cpu_pc == HALT_PC);
  assign hit_limit = ((cycle_count + CNT_W'(1)) == CNT_W'(MAX_CYCLES));
  assign dump_go   = (state == S_RUN) && (hit_halt || hit_limit);

  // The state register holds S_DUMP_SEL for the whole dump; the sequencer's
  // phase splits it into DUMP_SEL/DUMP_OUT for observation.
  always_comb begin
    dbg_state = state;
    if (state == S_DUMP_SEL && dump_out_phase) dbg_state = S_DUMP_OUT;
  end

  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE, S_DONE: if (start) state_nx = S_RESET;
      S_RESET:        if (rst_cnt == RC_W'(1)) state_nx = S_RUN;
      S_RUN:          if (hit_halt || hit_limit) state_nx = S_DUMP_SEL;
      S_DUMP_SEL:     if (dump_finished) state_nx = S_DONE;
      default:        state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= S_IDLE;
      rst_cnt     <= '0;
      cycle_count <= '0;
      halted      <= 1'b0;
      timeout     <= 1'b0;
      cpu_rstn    <= 1'b0;
      cpu_run     <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
    end else begin
      state <= state_nx;
      busy  <= (state_nx != S_IDLE) && (state_nx != S_DONE);
      done  <= (state_nx == S_DONE);
      case (state)
        S_IDLE, S_DONE: begin
          if (start) begin
            rst_cnt     <= RC_W'(RST_CYCLES);
            cpu_rstn    <= 1'b0;
            cpu_run     <= 1'b0;
            halted      <= 1'b0;
            timeout     <= 1'b0;
            cycle_count <= '0;
          end
        end
        S_RESET: begin
          if (rst_cnt == RC_W'(1)) begin
            cpu_rstn <= 1'b1;
            cpu_run  <= 1'b1;
          end else begin
            rst_cnt <= rst_cnt - RC_W'(1);
          end
        end
        S_RUN: begin
          // Halt outranks the limit, so a tie reports halted with the count untouched.
          if (hit_halt) begin
            halted  <= 1'b1;
            cpu_run <= 1'b0;
          end else if (hit_limit) begin
            cycle_count <= CNT_W'(MAX_CYCLES);
            timeout     <= 1'b1;
            cpu_run     <= 1'b0;
          end else begin
            cycle_count <= cycle_count + CNT_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

  sccomp_reg_dump #(
    .REG_W    (REG_W),
    .SEL_W    (SEL_W),
    .NUM_REGS (NUM_REGS)
  ) u_dump (
    .clk        (clk),
    .rst        (rst),
    .go         (dump_go),
    .finished   (dump_finished),
    .out_phase  (dump_out_phase),
    .reg_sel    (reg_sel),
    .reg_data   (reg_data),
    .dump_valid (dump_valid),
    .dump_ready (dump_ready),
    .dump_idx   (dump_idx),
    .dump_data  (dump_data)
  );

endmodule
